i2c_slave_line_rx: RTL and testbench

Front-end receive stage for the I2C slave. It samples the raw SCL/SDA pins on a periodic sample strobe from the slave's clock divider/counter, then synchronizes and glitch-filters both lines. It detects SCL edges and START/STOP conditions, and assembles received bits into bytes plus an ACK slot. Its outputs feed the slave protocol FSM (address match, register access, ACK drive).

---
 rtl/i2c_slave_line_rx.sv | 187 ++++++++++++++++++
 tb/tb_i2c_slave_line_rx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_line_rx.sv
// I2C slave receive front end: pin synchronizers, glitch filters, SCL edge and
// START/STOP detection, and byte/ACK assembly for the protocol FSM.
module i2c_slave_line_rx #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_filt,
    output logic       sda_filt,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       ack_slot,
    output logic       ack_bit
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    logic              scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic              scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
    logic [CNT_W-1:0]  scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic              scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic              start_det_q, start_det_d, stop_det_q, stop_det_d;
    state_e            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d, byte_data_q, byte_data_d;
    logic              byte_valid_q, byte_valid_d, ack_slot_q, ack_slot_d;
    logic              ack_bit_q, ack_bit_d, bus_busy_q, bus_busy_d;

    // Filters: accept a change only after FILT_LEN consecutive differing ticks.
    always_comb begin
        scl_filt_d = scl_filt_q;
        scl_cnt_d  = scl_cnt_q;
        sda_filt_d = sda_filt_q;
        sda_cnt_d  = sda_cnt_q;
        if (tick) begin
            if (scl_s2_q != scl_filt_q) begin
                if ((scl_cnt_q + CNT_W'(1)) == CNT_W'(FILT_LEN)) begin
                    scl_filt_d = scl_s2_q;
                    scl_cnt_d  = '0;
                end else begin
                    scl_cnt_d = scl_cnt_q + CNT_W'(1);
                end
            end else begin
                scl_cnt_d = '0;
            end
            if (sda_s2_q != sda_filt_q) begin
                if ((sda_cnt_q + CNT_W'(1)) == CNT_W'(FILT_LEN)) begin
                    sda_filt_d = sda_s2_q;
                    sda_cnt_d  = '0;
                end else begin
                    sda_cnt_d = sda_cnt_q + CNT_W'(1);
                end
            end else begin
                sda_cnt_d = '0;
            end
        end
        scl_rise_d  = scl_filt_d & ~scl_filt_q;
        scl_fall_d  = ~scl_filt_d & scl_filt_q;
        // SCL must be high on both sides of the SDA edge, so simultaneous edges never qualify.
        start_det_d = scl_filt_q & scl_filt_d & sda_filt_q & ~sda_filt_d;
        stop_det_d  = scl_filt_q & scl_filt_d & ~sda_filt_q & sda_filt_d;
    end

    // Bit FSM consumes the registered event pulses, so byte/ack results land one clk later.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        ack_slot_d   = 1'b0;
        ack_bit_d    = ack_bit_q;
        bus_busy_d   = bus_busy_q;

        if (start_det_q) begin
            bus_busy_d = 1'b1;
        end else if (stop_det_q) begin
            bus_busy_d = 1'b0;
        end

        if (start_det_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (stop_det_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (scl_rise_q) begin
            case (state_q)
                S_DATA: begin
                    shift_d   = {shift_q[BYTE_W-2:0], sda_filt_q};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(BYTE_W - 1)) begin
                        byte_data_d  = shift_d;
                        byte_valid_d = 1'b1;
                        state_d      = S_ACK;
                    end
                end
                S_ACK: begin
                    ack_bit_d  = sda_filt_q;
                    ack_slot_d = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = S_DATA;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q     <= 1'b1;
            scl_s2_q     <= 1'b1;
            sda_s1_q     <= 1'b1;
            sda_s2_q     <= 1'b1;
            scl_filt_q   <= 1'b1;
            sda_filt_q   <= 1'b1;
            scl_cnt_q    <= '0;
            sda_cnt_q    <= '0;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            ack_slot_q   <= 1'b0;
            ack_bit_q    <= 1'b1;
            bus_busy_q   <= 1'b0;
        end else begin
            scl_s1_q     <= scl_in;
            scl_s2_q     <= scl_s1_q;
            sda_s1_q     <= sda_in;
            sda_s2_q     <= sda_s1_q;
            scl_filt_q   <= scl_filt_d;
            sda_filt_q   <= sda_filt_d;
            scl_cnt_q    <= scl_cnt_d;
            sda_cnt_q    <= sda_cnt_d;
            scl_rise_q   <= scl_rise_d;
            scl_fall_q   <= scl_fall_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            ack_slot_q   <= ack_slot_d;
            ack_bit_q    <= ack_bit_d;
            bus_busy_q   <= bus_busy_d;
        end
    end

    assign scl_filt   = scl_filt_q;
    assign sda_filt   = sda_filt_q;
    assign scl_rise   = scl_rise_q;
    assign scl_fall   = scl_fall_q;
    assign start_det  = start_det_q;
    assign stop_det   = stop_det_q;
    assign bus_busy   = bus_busy_q;
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign ack_slot   = ack_slot_q;
    assign ack_bit    = ack_bit_q;

endmodule

// File: tb/tb_i2c_slave_line_rx.sv
// Bench for i2c_slave_line_rx: cycle model built from pin history and a bit queue,
// directed I2C transactions plus randomized pin/tick stress.
module tb_i2c_slave_line_rx;

    localparam int unsigned FILT_LEN = 3;
    localparam int H = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det;
    logic       bus_busy, byte_valid, ack_slot, ack_bit;
    logic [7:0] byte_data;

    i2c_slave_line_rx #(.FILT_LEN(FILT_LEN)) dut (
        .clk(clk), .rst(rst), .tick(tick), .scl_in(scl_in), .sda_in(sda_in),
        .scl_filt(scl_filt), .sda_filt(sda_filt), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
        .byte_data(byte_data), .byte_valid(byte_valid), .ack_slot(ack_slot), .ack_bit(ack_bit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Tick source: 0 = every 4 clk, 1 = held high, 2 = random.
    int tick_mode = 0;
    int tick_ph = 0;
    always @(negedge clk) begin
        case (tick_mode)
            0: begin
                tick_ph = (tick_ph + 1) % 4;
                tick = (tick_ph == 0);
            end
            1: tick = 1'b1;
            default: tick = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Reference model: filter input is the pin value sampled two clk edges earlier.
    bit h1_scl = 1, h2_scl = 1, h1_sda = 1, h2_sda = 1;
    bit m_scl = 1, m_sda = 1, m_rise = 0, m_fall = 0, m_start = 0, m_stop = 0;
    bit m_busy = 0, m_bv = 0, m_as = 0, m_ack = 1, in_frame = 0;
    logic [7:0] m_byte = 8'h00;
    int r_scl = 0, r_sda = 0;
    bit mq[$];

    always @(posedge clk) begin : model
        bit o_scl, o_sda, sv_scl, sv_sda;
        logic [7:0] v;
        if (rst) begin
            h1_scl = 1; h2_scl = 1; h1_sda = 1; h2_sda = 1;
            m_scl = 1; m_sda = 1; r_scl = 0; r_sda = 0;
            m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
            m_busy = 0; m_bv = 0; m_as = 0; m_ack = 1; m_byte = 8'h00;
            in_frame = 0; mq.delete();
        end else begin
            m_bv = 0;
            m_as = 0;
            if (m_start) m_busy = 1;
            else if (m_stop) m_busy = 0;
            if (m_start) begin
                in_frame = 1;
                mq.delete();
            end else if (m_stop) begin
                in_frame = 0;
                mq.delete();
            end else if (m_rise && in_frame) begin
                if (mq.size() == 8) begin
                    m_ack = m_sda;
                    m_as = 1;
                    mq.delete();
                end else begin
                    mq.push_back(m_sda);
                    if (mq.size() == 8) begin
                        v = 8'h00;
                        foreach (mq[i]) v = 8'(v * 2 + 32'(mq[i]));
                        m_byte = v;
                        m_bv = 1;
                    end
                end
            end
            sv_scl = h2_scl; sv_sda = h2_sda;
            h2_scl = h1_scl; h1_scl = scl_in;
            h2_sda = h1_sda; h1_sda = sda_in;
            o_scl = m_scl; o_sda = m_sda;
            if (tick) begin
                if (sv_scl != m_scl) begin
                    r_scl++;
                    if (r_scl == FILT_LEN) begin m_scl = sv_scl; r_scl = 0; end
                end else r_scl = 0;
                if (sv_sda != m_sda) begin
                    r_sda++;
                    if (r_sda == FILT_LEN) begin m_sda = sv_sda; r_sda = 0; end
                end else r_sda = 0;
            end
            m_rise  = m_scl && !o_scl;
            m_fall  = !m_scl && o_scl;
            m_start = o_scl && m_scl && o_sda && !m_sda;
            m_stop  = o_scl && m_scl && !o_sda && m_sda;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("scl_filt", 32'(scl_filt), 32'(m_scl));
            chk("sda_filt", 32'(sda_filt), 32'(m_sda));
            chk("scl_rise", 32'(scl_rise), 32'(m_rise));
            chk("scl_fall", 32'(scl_fall), 32'(m_fall));
            chk("start_det", 32'(start_det), 32'(m_start));
            chk("stop_det", 32'(stop_det), 32'(m_stop));
            chk("bus_busy", 32'(bus_busy), 32'(m_busy));
            chk("byte_data", 32'(byte_data), 32'(m_byte));
            chk("byte_valid", 32'(byte_valid), 32'(m_bv));
            chk("ack_slot", 32'(ack_slot), 32'(m_as));
            chk("ack_bit", 32'(ack_bit), 32'(m_ack));
        end
    end

    // Event counters for the literal checks.
    int cyc = 0, n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_bv = 0, n_as = 0;
    int last_rise_cyc = 0, bv_gap = 0, as_gap = 0;
    logic [7:0] last_byte = 8'h00;
    logic last_ack = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (scl_rise === 1'b1) begin n_rise++; last_rise_cyc = cyc; end
        if (scl_fall === 1'b1) n_fall++;
        if (start_det === 1'b1) n_start++;
        if (stop_det === 1'b1) n_stop++;
        if (byte_valid === 1'b1) begin n_bv++; bv_gap = cyc - last_rise_cyc; last_byte = byte_data; end
        if (ack_slot === 1'b1) begin n_as++; as_gap = cyc - last_rise_cyc; last_ack = ack_bit; end
    end

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic i2c_start();
        sda_in = 1; clk_n(H);
        scl_in = 1; clk_n(H);
        sda_in = 0; clk_n(H);
        scl_in = 0; clk_n(H);
    endtask

    task automatic i2c_bit(input bit b);
        sda_in = b; clk_n(H);
        scl_in = 1; clk_n(H);
        scl_in = 0; clk_n(H);
    endtask

    task automatic i2c_stop();
        sda_in = 0; clk_n(H);
        scl_in = 1; clk_n(H);
        sda_in = 1; clk_n(H);
    endtask

    task automatic i2c_byte(input logic [7:0] b, input bit ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        i2c_bit(ack);
    endtask

    initial begin
        int b_rise, b_fall, b_start, b_stop, b_bv, b_as, lat;
        logic [7:0] rb;
        bit ra;

        clk_n(3);
        chk_en = 1;
        rst = 0;

        // Idle after reset: nothing happens for 100 clk.
        b_rise = n_rise; b_fall = n_fall; b_start = n_start; b_stop = n_stop; b_bv = n_bv; b_as = n_as;
        clk_n(100);
        chk("rst_scl_filt", 32'(scl_filt), 32'd1);
        chk("rst_sda_filt", 32'(sda_filt), 32'd1);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_byte", 32'(byte_data), 32'h00);
        chk("rst_ack_bit", 32'(ack_bit), 32'd1);
        chk("rst_pulses", 32'(n_rise + n_fall + n_start + n_stop + n_bv + n_as
                              - b_rise - b_fall - b_start - b_stop - b_bv - b_as), 32'd0);

        // Glitches: 2-tick low rejected, 3-tick low accepted.
        b_fall = n_fall;
        scl_in = 0; clk_n(8);
        scl_in = 1; clk_n(30);
        chk("glitch2_fall", 32'(n_fall - b_fall), 32'd0);
        scl_in = 0; clk_n(12);
        scl_in = 1; clk_n(30);
        chk("glitch3_fall", 32'(n_fall - b_fall), 32'd1);

        // Latency with tick held high: 2 sync clk + 3 ticks.
        tick_mode = 1;
        clk_n(4);
        scl_in = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            clk_n(1);
            if (scl_fall === 1'b1 && lat == 0) lat = k;
        end
        chk("fall_latency", 32'(lat), 32'd5);
        scl_in = 1; clk_n(10);
        tick_mode = 0;
        clk_n(8);

        // START, 0xA5, ACK=0, STOP.
        b_rise = n_rise; b_start = n_start; b_stop = n_stop; b_bv = n_bv; b_as = n_as;
        i2c_start();
        chk("a5_busy", 32'(bus_busy), 32'd1);
        i2c_byte(8'hA5, 1'b0);
        chk("a5_start", 32'(n_start - b_start), 32'd1);
        chk("a5_rises", 32'(n_rise - b_rise), 32'd9);
        chk("a5_bv", 32'(n_bv - b_bv), 32'd1);
        chk("a5_byte", 32'(last_byte), 32'hA5);
        chk("a5_bv_gap", 32'(bv_gap), 32'd1);
        chk("a5_as", 32'(n_as - b_as), 32'd1);
        chk("a5_ack", 32'(last_ack), 32'd0);
        chk("a5_as_gap", 32'(as_gap), 32'd1);
        i2c_stop();
        chk("a5_stop", 32'(n_stop - b_stop), 32'd1);
        chk("a5_busy_off", 32'(bus_busy), 32'd0);

        // Repeated START after 3 bits, then 0x3C.
        b_start = n_start; b_bv = n_bv;
        i2c_start();
        i2c_bit(1); i2c_bit(0); i2c_bit(1);
        i2c_start();
        chk("rs_busy", 32'(bus_busy), 32'd1);
        chk("rs_start", 32'(n_start - b_start), 32'd2);
        chk("rs_no_bv", 32'(n_bv - b_bv), 32'd0);
        i2c_byte(8'h3C, 1'b1);
        chk("rs_byte", 32'(last_byte), 32'h3C);
        chk("rs_ack", 32'(ack_bit), 32'd1);

        // STOP after 5 bits discards the partial byte; later rises ignored.
        b_bv = n_bv; b_as = n_as;
        i2c_bit(1); i2c_bit(1); i2c_bit(0); i2c_bit(0); i2c_bit(1);
        i2c_stop();
        for (int i = 0; i < 10; i++) i2c_bit(1);
        sda_in = 1; scl_in = 1; clk_n(H);
        chk("part_no_bv", 32'(n_bv - b_bv), 32'd0);
        chk("part_no_as", 32'(n_as - b_as), 32'd0);
        chk("part_byte", 32'(byte_data), 32'h3C);

        // Simultaneous SCL/SDA changes: edges only, no START/STOP.
        b_start = n_start; b_stop = n_stop; b_rise = n_rise; b_fall = n_fall;
        scl_in = 0; sda_in = 0; clk_n(H);
        scl_in = 1; sda_in = 1; clk_n(H);
        chk("sim_start", 32'(n_start - b_start), 32'd0);
        chk("sim_stop", 32'(n_stop - b_stop), 32'd0);
        chk("sim_fall", 32'(n_fall - b_fall), 32'd1);
        chk("sim_rise", 32'(n_rise - b_rise), 32'd1);

        // Reset in the middle of a byte.
        i2c_start();
        i2c_bit(1); i2c_bit(0); i2c_bit(1);
        rst = 1;
        clk_n(1);
        chk("mrst_scl", 32'(scl_filt), 32'd1);
        chk("mrst_sda", 32'(sda_filt), 32'd1);
        chk("mrst_busy", 32'(bus_busy), 32'd0);
        chk("mrst_byte", 32'(byte_data), 32'h00);
        chk("mrst_ack", 32'(ack_bit), 32'd1);
        chk("mrst_pulses", 32'({scl_rise, scl_fall, start_det, stop_det, byte_valid, ack_slot}), 32'd0);
        rst = 0;
        scl_in = 1; sda_in = 1; clk_n(2 * H);

        // Random bytes through full transactions.
        for (int t = 0; t < 4; t++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            i2c_start();
            i2c_byte(rb, ra);
            chk("rnd_byte", 32'(last_byte), 32'(rb));
            chk("rnd_ack", 32'(last_ack), 32'(ra));
            i2c_stop();
        end

        // Random pins and random tick; the model checks every cycle.
        tick_mode = 2;
        for (int s = 0; s < 1500; s++) begin
            scl_in = 1'($urandom_range(0, 1));
            sda_in = 1'($urandom_range(0, 1));
            clk_n($urandom_range(1, 16));
        end
        scl_in = 1; sda_in = 1; clk_n(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
